// File: rtl/sram_req_arbiter_if.sv
// ============================================================================
// Module  : sram_req_arbiter_if
// Brief   : SRAM-like req/addr_ok/data_ok bus. The master issues requests;
//           the slave accepts address phases and returns responses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_req_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [3:0]    wstrb;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [DW-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

`default_nettype wire

// File: rtl/sram_req_arbiter.sv
// ============================================================================
// Module  : sram_req_arbiter
// Brief   : Shares one SRAM-like port between fetch (I) and load/store (D).
//           Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration
//           instead of fixed D-over-I priority. OUT_LG must be >= 1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_req_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int OUT_LG = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  sram_req_arbiter_if.slave      i_fetch,
  sram_req_arbiter_if.slave      i_lsu,
  sram_req_arbiter_if.master     o_mem
);

  localparam int                DEPTH     = 1 << OUT_LG;
  localparam logic [OUT_LG:0]   c_DEPTH   = {1'b1, {OUT_LG{1'b0}}};
  localparam logic [OUT_LG:0]   c_CNT_ONE = {{OUT_LG{1'b0}}, 1'b1};
  localparam logic [OUT_LG-1:0] c_PTR_ONE = {{(OUT_LG-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCK_I = 2'd1,
    S_LOCK_D = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DEPTH-1:0]  r_fifo;
  logic [OUT_LG-1:0] r_wptr;
  logic [OUT_LG-1:0] r_rptr;
  logic [OUT_LG:0]   r_count;

  logic          w_req;
  logic          w_grant_d;
  logic          w_pick_d;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_can_push;
  logic          w_head_d;
  logic          w_wr;
  logic [1:0]    w_size;
  logic [3:0]    w_wstrb;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_unused;

  assign w_full     = (r_count == c_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_pop      = o_mem.data_ok & ~w_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign w_can_push = ~w_full | w_pop;
  assign w_push     = w_req & o_mem.addr_ok;
  assign w_head_d   = r_fifo[r_rptr];

`ifdef ARB_ROUND_ROBIN_EN
  logic r_rr_last_d;

  assign w_pick_d = i_lsu.req & (~i_fetch.req | ~r_rr_last_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_last_d <= 1'b0;
    end else if (w_push) begin
      r_rr_last_d <= w_grant_d;
    end
  end
`else
  assign w_pick_d = i_lsu.req;
`endif

  always_comb begin
    w_req       = 1'b0;
    w_grant_d   = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_can_push && (i_fetch.req || i_lsu.req)) begin
          w_req     = 1'b1;
          w_grant_d = w_pick_d;
          if (!o_mem.addr_ok) begin
            w_state_nxt = w_pick_d ? S_LOCK_D : S_LOCK_I;
          end
        end
      end
      S_LOCK_I: begin
        w_req = 1'b1;
        if (o_mem.addr_ok) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOCK_D: begin
        w_req     = 1'b1;
        w_grant_d = 1'b1;
        if (o_mem.addr_ok) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr    = 1'b0;
    w_size  = 2'd0;
    w_wstrb = 4'd0;
    w_addr  = '0;
    w_wdata = '0;
    if (w_req) begin
      if (w_grant_d) begin
        w_wr    = i_lsu.wr;
        w_size  = i_lsu.size;
        w_wstrb = i_lsu.wstrb;
        w_addr  = i_lsu.addr;
        w_wdata = i_lsu.wdata;
      end else begin
        w_size  = 2'd2;
        w_addr  = i_fetch.addr;
      end
    end
  end

  assign o_mem.req   = w_req;
  assign o_mem.wr    = w_wr;
  assign o_mem.size  = w_size;
  assign o_mem.wstrb = w_wstrb;
  assign o_mem.addr  = w_addr;
  assign o_mem.wdata = w_wdata;

  assign i_fetch.addr_ok = w_push & ~w_grant_d;
  assign i_lsu.addr_ok   = w_push &  w_grant_d;
  assign i_fetch.data_ok = w_pop  & ~w_head_d;
  assign i_lsu.data_ok   = w_pop  &  w_head_d;
  assign i_fetch.rdata   = o_mem.rdata;
  assign i_lsu.rdata     = o_mem.rdata;

  // Fetch is read-only word access; its write-side fields are ignored.
  assign w_unused = ^{i_fetch.wr, i_fetch.size, i_fetch.wstrb, i_fetch.wdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fifo  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_grant_d;
        r_wptr         <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire
